snake_step_ctrl: RTL and testbench

Step sequencer for the snake game datapath, in the `uclk` domain. On each rising edge of the `mover` step tick it runs a fixed phase sequence: check, grow or shift, move head. While doing so it commits the requested direction with an anti-reversal rule, tracks body length, requests fruit respawn and owns the game-over / game-reset pulse. The head/body register file and the fruit module remain datapath; this block only commands them.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_step_ctrl_if.sv | 30 +++
 rtl/mover_sync_edge.sv | 26 ++
 rtl/snake_step_ctrl.sv | 176 +++++++++++++++++
 tb/tb_snake_step_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake step controller.
// - Direction codes (none/up/down/left/right), FSM state type, default body length limit.
// - reverse_dir(): opposite direction of a code; DirNone for none/invalid codes.
package snake_pkg;

    localparam logic [2:0] DirNone  = 3'd0;
    localparam logic [2:0] DirUp    = 3'd1;
    localparam logic [2:0] DirDown  = 3'd2;
    localparam logic [2:0] DirLeft  = 3'd3;
    localparam logic [2:0] DirRight = 3'd4;

    localparam int unsigned MaxLenDefault = 25;
    localparam int unsigned LenW          = 5;

    typedef enum logic [2:0] {
        StRstHold,
        StIdle,
        StCheck,
        StUpdate,
        StWaitBody,
        StMove
    } state_e;

    function automatic logic [2:0] reverse_dir(input logic [2:0] d);
        case (d)
            DirUp:    return DirDown;
            DirDown:  return DirUp;
            DirLeft:  return DirRight;
            DirRight: return DirLeft;
            default:  return DirNone;
        endcase
    endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// Bundle between the step controller and the snake datapath.
// master: controller side (takes tick/request/hit/busy, drives commands).
// slave:  datapath side (drives tick/request/hit/busy, takes commands).
// Signals: mover, accion[2:0], fruit_hit, wall_hit, body_hit, body_busy,
//          dir[2:0], step_grow, step_shift, step_move, comer, reset, length[4:0].
interface snake_step_ctrl_if;
    logic                       mover;
    logic [2:0]                 accion;
    logic                       fruit_hit;
    logic                       wall_hit;
    logic                       body_hit;
    logic                       body_busy;
    logic [2:0]                 dir;
    logic                       step_grow;
    logic                       step_shift;
    logic                       step_move;
    logic                       comer;
    logic                       reset;
    logic [snake_pkg::LenW-1:0] length;

    modport master (
        input  mover, accion, fruit_hit, wall_hit, body_hit, body_busy,
        output dir, step_grow, step_shift, step_move, comer, reset, length
    );

    modport slave (
        output mover, accion, fruit_hit, wall_hit, body_hit, body_busy,
        input  dir, step_grow, step_shift, step_move, comer, reset, length
    );
endinterface

// File: rtl/mover_sync_edge.sv
// Brings the slow-timebase step tick into the uclk domain and detects its rising edge.
// Ports: uclk (clock), rst (async active-high), mover_i (async level), tick_o (1-cycle pulse).
// tick_o is high in the cycle after the second synchronizer stage first sees a 1.
module mover_sync_edge (
    input  logic uclk,
    input  logic rst,
    input  logic mover_i,
    output logic tick_o
);
    // [0],[1]: synchronizer stages, [2]: previous synchronized value
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], mover_i};
    end

    always_ff @(posedge uclk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign tick_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/snake_step_ctrl.sv
// Step sequencer for the snake datapath: per mover tick runs check -> grow/shift -> move,
// commits the requested direction (no reversal while the body is non-empty), tracks
// body length, requests fruit respawn and owns the game reset.
// Ports: uclk, rst (async active-high), bus (snake_step_ctrl_if.master).
// Build option: SNAKE_SELF_COLLIDE_EN -- when defined body_hit in CHECK ends the game,
// otherwise body_hit is ignored.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN      = MaxLenDefault,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned BODY_TIMEOUT = 32
) (
    input  logic                 uclk,
    input  logic                 rst,
    snake_step_ctrl_if.master    bus
);
    // One counter serves both the reset hold and the body-busy timeout.
    localparam int unsigned CntMax = (RESET_CYCLES > BODY_TIMEOUT) ? RESET_CYCLES : BODY_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] RstLast  = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0] BodyLast = CntW'(BODY_TIMEOUT - 1);
    localparam logic [LenW-1:0] MaxLen   = LenW'(MAX_LEN);

    logic tick;
    logic game_over;
    logic req_ok;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      dir_q, dir_d;
    logic [2:0]      pdir_q, pdir_d;
    logic [LenW-1:0] len_q, len_d;
    logic            pend_q, pend_d;
    logic            grow_q, grow_d;
    logic            shift_q, shift_d;
    logic            move_q, move_d;
    logic            comer_q, comer_d;

    mover_sync_edge u_mover_sync_edge (
        .uclk    (uclk),
        .rst     (rst),
        .mover_i (bus.mover),
        .tick_o  (tick)
    );

`ifdef SNAKE_SELF_COLLIDE_EN
    assign game_over = bus.wall_hit | bus.body_hit;
`else
    assign game_over = bus.wall_hit;
    logic unused_body_hit;
    assign unused_body_hit = bus.body_hit;
`endif

    // Valid request that is not a reversal of the committed direction of a non-empty body.
    assign req_ok = (bus.accion != DirNone) && (bus.accion <= DirRight) &&
                    !((len_q != '0) && (bus.accion == reverse_dir(dir_q)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pdir_d  = pdir_q;
        len_d   = len_q;
        pend_d  = pend_q;
        grow_d  = 1'b0;
        shift_d = 1'b0;
        move_d  = 1'b0;
        comer_d = 1'b0;

        if (req_ok) begin
            pdir_d = bus.accion;
        end

        // One-deep memory for a tick that lands mid-step; extra ticks are lost.
        if (tick && (state_q != StIdle) && (state_q != StRstHold)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StRstHold: begin
                if (cnt_q == RstLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (tick || pend_q) begin
                    state_d = StCheck;
                    pend_d  = 1'b0;
                end
            end
            StCheck: begin
                dir_d = pdir_q;
                if (game_over) begin
                    state_d = StRstHold;
                end else begin
                    state_d = StUpdate;
                    comer_d = bus.fruit_hit;
                    if (bus.fruit_hit && (len_q < MaxLen)) begin
                        grow_d = 1'b1;
                        len_d  = len_q + 1'b1;
                    end else begin
                        shift_d = 1'b1;
                    end
                end
            end
            StUpdate: begin
                state_d = StWaitBody;
                // Counts cycles since UPDATE so the timeout lands BODY_TIMEOUT after it.
                cnt_d   = CntW'(1);
            end
            StWaitBody: begin
                if (!bus.body_busy) begin
                    state_d = StMove;
                    move_d  = 1'b1;
                end else if (cnt_q >= BodyLast) begin
                    state_d = StRstHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMove: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StRstHold;
            end
        endcase

        if ((state_d == StRstHold) && (state_q != StRstHold)) begin
            cnt_d = '0;
        end
        if (state_d == StRstHold) begin
            dir_d  = DirNone;
            pdir_d = DirNone;
            len_d  = '0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge uclk or posedge rst) begin
        if (rst) begin
            state_q <= StRstHold;
            cnt_q   <= '0;
            dir_q   <= DirNone;
            pdir_q  <= DirNone;
            len_q   <= '0;
            pend_q  <= 1'b0;
            grow_q  <= 1'b0;
            shift_q <= 1'b0;
            move_q  <= 1'b0;
            comer_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pdir_q  <= pdir_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            grow_q  <= grow_d;
            shift_q <= shift_d;
            move_q  <= move_d;
            comer_q <= comer_d;
        end
    end

    assign bus.dir        = dir_q;
    assign bus.length     = len_q;
    assign bus.reset      = (state_q == StRstHold);
    assign bus.step_grow  = grow_q;
    assign bus.step_shift = shift_q;
    assign bus.step_move  = move_q;
    assign bus.comer      = comer_q;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl: reset hold, plain step timing, growth and saturation,
// anti-reversal, game over, body timeout, tick queueing and asynchronous reset.
module tb_snake_step_ctrl;
    logic uclk;
    logic rst;

    snake_step_ctrl_if bus();

    snake_step_ctrl #(
        .MAX_LEN      (25),
        .RESET_CYCLES (4),
        .BODY_TIMEOUT (32)
    ) dut (
        .uclk (uclk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int bad_pulse = 0;

    // First sample index (1-based, 0 = never) and count of each output during a step.
    int shift_at, grow_at, move_at, comer_at, reset_at;
    int shift_n, grow_n, move_n, comer_n, reset_n;
    int shift2_at;

    initial begin
        uclk = 1'b0;
        forever #5 uclk = ~uclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    always @(negedge uclk) begin
        if (bus.reset && (bus.step_grow || bus.step_shift || bus.step_move || bus.comer)) begin
            bad_pulse <= bad_pulse + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_rec();
        shift_at = 0; grow_at = 0; move_at = 0; comer_at = 0; reset_at = 0;
        shift_n = 0; grow_n = 0; move_n = 0; comer_n = 0; reset_n = 0;
        shift2_at = 0;
    endtask

    task automatic sample(input int k);
        if (bus.step_shift) begin
            shift_n++;
            if (shift_at == 0) shift_at = k;
            else if (shift2_at == 0) shift2_at = k;
        end
        if (bus.step_grow) begin grow_n++; if (grow_at == 0) grow_at = k; end
        if (bus.step_move) begin move_n++; if (move_at == 0) move_at = k; end
        if (bus.comer) begin comer_n++; if (comer_at == 0) comer_at = k; end
        if (bus.reset) begin reset_n++; if (reset_at == 0) reset_at = k; end
    endtask

    // One mover rise at sample 0, observed for n negedges.
    task automatic do_step(input logic [2:0] req, input logic fruit, input logic wall,
                           input logic busy, input int n);
        clr_rec();
        @(negedge uclk);
        bus.accion    = req;
        bus.fruit_hit = fruit;
        bus.wall_hit  = wall;
        bus.body_busy = busy;
        bus.mover     = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge uclk);
            if (k == 3) bus.mover = 1'b0;
            sample(k);
        end
        bus.accion    = 3'd0;
        bus.fruit_hit = 1'b0;
        bus.wall_hit  = 1'b0;
        bus.body_busy = 1'b0;
    endtask

    initial begin
        int hold;
        rst = 1'b0;
        bus.mover = 1'b0;
        bus.accion = 3'd0;
        bus.fruit_hit = 1'b0;
        bus.wall_hit = 1'b0;
        bus.body_hit = 1'b0;
        bus.body_busy = 1'b0;
        #1 rst = 1'b1;

        // Reset sequence
        repeat (2) @(negedge uclk);
        check_eq("rst_reset", bus.reset, 1);
        check_eq("rst_dir", bus.dir, 0);
        check_eq("rst_length", bus.length, 0);
        check_eq("rst_pulses", {bus.step_grow, bus.step_shift, bus.step_move, bus.comer}, 0);
        @(posedge uclk);
        #1 rst = 1'b0;
        hold = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge uclk);
            if (bus.reset) hold++;
        end
        check_eq("rst_hold_cycles", hold, 4);
        clr_rec();
        for (int k = 1; k <= 6; k++) begin
            @(negedge uclk);
            sample(k);
        end
        check_eq("idle_no_pulses", shift_n + grow_n + move_n + comer_n + reset_n, 0);

        // Plain step to the right
        do_step(3'd4, 1'b0, 1'b0, 1'b0, 8);
        check_eq("plain_dir", bus.dir, 4);
        check_eq("plain_shift_at", shift_at, 4);
        check_eq("plain_move_at", move_at, 6);
        check_eq("plain_counts", {8'(shift_n), 8'(move_n), 8'(grow_n), 8'(comer_n)},
                 {8'd1, 8'd1, 8'd0, 8'd0});
        check_eq("plain_length", bus.length, 0);

        // Invalid request is ignored
        do_step(3'd6, 1'b0, 1'b0, 1'b0, 8);
        check_eq("invalid_dir", bus.dir, 4);

        // Growth: two plain grows then a reverse request at length 2
        do_step(3'd0, 1'b1, 1'b0, 1'b0, 8);
        check_eq("grow1_grow_at", grow_at, 4);
        check_eq("grow1_comer_at", comer_at, 4);
        check_eq("grow1_shift_n", shift_n, 0);
        check_eq("grow1_length", bus.length, 1);
        do_step(3'd0, 1'b1, 1'b0, 1'b0, 8);
        check_eq("grow2_length", bus.length, 2);
        do_step(3'd3, 1'b1, 1'b0, 1'b0, 8);
        check_eq("antirev_dir", bus.dir, 4);
        check_eq("grow3_counts", {8'(grow_n), 8'(comer_n), 8'(move_n)}, {8'd1, 8'd1, 8'd1});
        check_eq("grow3_length", bus.length, 3);

        // Fill to the limit, then one more fruit
        for (int i = 0; i < 22; i++) do_step(3'd0, 1'b1, 1'b0, 1'b0, 8);
        check_eq("full_length", bus.length, 25);
        do_step(3'd0, 1'b1, 1'b0, 1'b0, 8);
        check_eq("sat_comer_at", comer_at, 4);
        check_eq("sat_shift_at", shift_at, 4);
        check_eq("sat_grow_n", grow_n, 0);
        check_eq("sat_length", bus.length, 25);

        // Wall and fruit together: game over, no respawn
        do_step(3'd0, 1'b1, 1'b1, 1'b0, 8);
        check_eq("wall_comer_n", comer_n, 0);
        check_eq("wall_step_n", shift_n + grow_n + move_n, 0);
        check_eq("wall_reset_at", reset_at, 4);
        check_eq("wall_reset_n", reset_n, 4);
        check_eq("wall_length", bus.length, 0);
        check_eq("wall_dir", bus.dir, 0);

        // Reverse request allowed with empty body
        do_step(3'd4, 1'b0, 1'b0, 1'b0, 8);
        check_eq("len0_dir_right", bus.dir, 4);
        do_step(3'd3, 1'b0, 1'b0, 1'b0, 8);
        check_eq("len0_dir_left", bus.dir, 3);

        // Body busy timeout
        do_step(3'd0, 1'b1, 1'b0, 1'b0, 8);
        check_eq("pre_timeout_length", bus.length, 1);
        do_step(3'd0, 1'b0, 1'b0, 1'b1, 40);
        check_eq("timeout_shift_at", shift_at, 4);
        check_eq("timeout_move_n", move_n, 0);
        check_eq("timeout_reset_at", reset_at, 36);
        check_eq("timeout_reset_n", reset_n, 4);
        check_eq("timeout_length", bus.length, 0);

        // Two extra rises while waiting on the body: one extra step only
        clr_rec();
        @(negedge uclk);
        bus.body_busy = 1'b1;
        bus.mover = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge uclk);
            case (k)
                3, 9, 15: bus.mover = 1'b0;
                6, 12:    bus.mover = 1'b1;
                20:       bus.body_busy = 1'b0;
                default: ;
            endcase
            sample(k);
        end
        check_eq("dbl_shift_n", shift_n, 2);
        check_eq("dbl_move_n", move_n, 2);
        check_eq("dbl_first_shift", shift_at, 4);
        check_eq("dbl_second_shift", shift2_at, 24);
        check_eq("dbl_reset_n", reset_n, 0);

        // Asynchronous reset mid-game
        do_step(3'd1, 1'b1, 1'b0, 1'b0, 8);
        check_eq("pre_arst_length", bus.length, 1);
        @(negedge uclk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_reset", bus.reset, 1);
        check_eq("arst_length", bus.length, 0);
        check_eq("arst_dir", bus.dir, 0);
        @(posedge uclk);
        #1 rst = 1'b0;
        repeat (6) @(negedge uclk);
        check_eq("arst_release", bus.reset, 0);

        check_eq("no_pulse_in_reset", bad_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
